// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format codes and instruction field positions
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_B  = 3'b000,
      FMT_CB = 3'b001,
      FMT_I  = 3'b010,
      FMT_D  = 3'b011,
      FMT_IW = 3'b100
   } fmt_e;

   // Every format is built at this width before truncation to DATA_W
   localparam int FULL_W = 64;

   localparam int B_MSB     = 25;
   localparam int B_LSB     = 0;
   localparam int CB_MSB    = 23;
   localparam int CB_LSB    = 5;
   localparam int I_MSB     = 21;
   localparam int I_LSB     = 10;
   localparam int D_MSB     = 20;
   localparam int D_LSB     = 12;
   localparam int IW_MSB    = 20;
   localparam int IW_LSB    = 5;
   localparam int IW_HW_MSB = 22;
   localparam int IW_HW_LSB = 21;

   localparam int B_W  = B_MSB - B_LSB + 1;
   localparam int CB_W = CB_MSB - CB_LSB + 1;
   localparam int I_W  = I_MSB - I_LSB + 1;
   localparam int D_W  = D_MSB - D_LSB + 1;
   localparam int IW_W = IW_MSB - IW_LSB + 1;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extraction and extension
// Format 100 (IW) is decoded only when IMM_EXTEND_IW_EN is defined.
module imm_decode
   import imm_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [31:0]       instr,
   input  logic [2:0]        fmt,
   output logic [DATA_W-1:0] imm,
   output logic              err
);

   logic [FULL_W-1:0] full;
   logic              unused_bits;

   always_comb begin
      full = '0;
      err  = 1'b0;
      case (fmt)
         FMT_B:  full = {{(FULL_W-B_W-2){instr[B_MSB]}}, instr[B_MSB:B_LSB], 2'b00};
         FMT_CB: full = {{(FULL_W-CB_W-2){instr[CB_MSB]}}, instr[CB_MSB:CB_LSB], 2'b00};
         FMT_I:  full = {{(FULL_W-I_W){1'b0}}, instr[I_MSB:I_LSB]};
         FMT_D:  full = {{(FULL_W-D_W){instr[D_MSB]}}, instr[D_MSB:D_LSB]};
         FMT_IW: begin
`ifdef IMM_EXTEND_IW_EN
            full = {{(FULL_W-IW_W){1'b0}}, instr[IW_MSB:IW_LSB]}
                   << {instr[IW_HW_MSB:IW_HW_LSB], 4'b0000};
            // A 32-bit result cannot hold halfword positions 2 and 3
            if (DATA_W == 32 && instr[IW_HW_MSB]) begin
               full = '0;
               err  = 1'b1;
            end
`else
            err = 1'b1;
`endif
         end
         default: err = 1'b1;
      endcase
   end

   assign imm         = full[DATA_W-1:0];
   assign unused_bits = ^{instr[31:26], full};

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender with a DEPTH-entry output FIFO
// Format 100 (IW) is enabled by defining IMM_EXTEND_IW_EN.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [2:0]        fmt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] imm,
   output logic              imm_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] dec_imm;
   logic              dec_err;
   logic              push;
   logic              pop;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              in_ready_q, in_ready_d;
   logic [DATA_W-1:0] imm_mem_q [DEPTH];
   logic              err_mem_q [DEPTH];

   imm_decode #(.DATA_W(DATA_W)) u_decode (
      .instr (instr),
      .fmt   (fmt),
      .imm   (dec_imm),
      .err   (dec_err)
   );

   // in_ready_q tracks count<DEPTH, so a full FIFO refuses a push even when popping
   assign push = in_valid && in_ready_q;
   assign pop  = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      in_ready_d = (count_d < CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         imm_mem_q[wr_ptr_q] <= dec_imm;
         err_mem_q[wr_ptr_q] <= dec_err;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (count_q != '0);
   assign imm       = out_valid ? imm_mem_q[rd_ptr_q] : '0;
   assign imm_err   = out_valid && err_mem_q[rd_ptr_q];

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the extended immediate width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the output buffer entries; legal values are 2 to 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the instruction and format are offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the offer this cycle.
REQ-007 The block SHALL have port instr, input, 32 bits: the instruction word.
REQ-008 The block SHALL have port fmt, input, 3 bits: the immediate format code.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head entry.
REQ-011 The block SHALL have port imm, output, DATA_W bits: the extended immediate.
REQ-012 The block SHALL have port imm_err, output, 1 bit: the head entry had an illegal or disabled format, or overflow.

Function
REQ-013 The block SHALL extend by format as follows:
- 000 B: sign-extended instr[25:0], shifted left by 2.
- 001 CB: sign-extended instr[23:5], shifted left by 2.
- 010 I: zero-extended instr[21:10].
- 011 D: sign-extended instr[20:12], with the sign taken from bit 20.
- 100 IW: zero-extended instr[20:5], shifted left by 16*instr[22:21].
REQ-014 Results SHALL be computed at full precision and then truncated to DATA_W.
REQ-015 Formats 101 to 111 SHALL produce imm=0 and imm_err=1.
REQ-016 With DATA_W=32, format IW with instr[22]=1 SHALL produce imm=0 and imm_err=1.
REQ-017 A transfer SHALL occur on in_valid&&in_ready; the result SHALL be written into a DEPTH-entry FIFO in the same edge.
REQ-018 Latency SHALL be exactly 1 cycle from acceptance into an empty FIFO to out_valid=1.
REQ-019 The block SHALL sustain one transfer per cycle.
REQ-020 in_ready SHALL be registered, equal to (count<DEPTH), and SHALL not depend combinationally on out_ready.
REQ-021 A pop SHALL occur on out_valid&&out_ready; imm and imm_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 When the FIFO is full, no push SHALL occur, even if a pop happens in the same cycle.
REQ-024 When the FIFO is empty, out_valid SHALL be 0 and imm SHALL be 0.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately clear count and pointers, and force out_valid=0, imm=0, imm_err=0, and in_ready=0.
REQ-027 in_ready SHALL rise in the first clk edge after reset_n deasserts.
REQ-028 A reset asserted mid-stream SHALL discard all buffered entries, with no partial output.

Configuration
REQ-029 Macro IMM_EXTEND_IW_EN defined SHALL enable format 100 as in REQ-013.
REQ-030 Without IMM_EXTEND_IW_EN, format 100 SHALL be treated as illegal, per REQ-015.

Structure
REQ-031 Package imm_pkg SHALL hold the format enum (FMT_B, FMT_CB, FMT_I, FMT_D, FMT_IW) and the field-position constants.
REQ-032 The extension logic SHALL be a combinational sub-module, imm_decode, with inputs instr and fmt and outputs imm and err, parametrised by DATA_W.
REQ-033 The FIFO and handshake SHALL reside in imm_extend_pipe.

Verification
REQ-034 Bench scenario, B format: DATA_W=64, instr[25:0]=26'h3FFFFFF, fmt=000 -> imm=64'hFFFF_FFFF_FFFF_FFFC one cycle later.
REQ-035 Bench scenario, D format: instr[20:12]=9'h100, fmt=011 -> imm=64'hFFFF_FFFF_FFFF_FF00; also I format with instr[21:10]=12'hFFF -> imm=64'h0000_0000_0000_0FFF.
REQ-036 Bench scenario, IW format with IMM_EXTEND_IW_EN defined: instr[20:5]=16'hBEEF, hw=3 -> imm=64'hBEEF_0000_0000_0000. With DATA_W=32 and hw=2 -> imm=0, imm_err=1. Without the macro -> imm=0, imm_err=1.
REQ-037 Bench scenario, backpressure: out_ready=0 and three pushes with DEPTH=2 -> in_ready=0 after two pushes, head stable. Then out_ready=1 -> entries pop in order and in_ready returns to 1.
REQ-038 Bench scenario, streaming: in_valid and out_ready held at 1 for 100 random instructions -> one output per cycle, results match the reference model, count never exceeds 1.
REQ-039 Bench scenario, reset mid-stream: FIFO holding 2 entries, reset_n pulsed low between edges -> out_valid=0 immediately, and no stale entry after release.
